// File: rtl/apb_i2c_regif_if.sv
// APB bus bundle between the fabric and the I2C register interface.
interface apb_i2c_regif_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_i2c_regif.sv
// APB slave register interface for the I2C controller: config registers,
// TX/RX FIFO handshakes with bounded wait states, sticky maskable interrupts.
//
// state  | meaning
// S_IDLE | no transfer pending, or a zero-wait access completing
// S_WAIT | FIFO access stalled on TX_READY / RX_VALID, wcnt counting
module apb_i2c_regif #(
    parameter int               ADDR_W   = 8,
    parameter int               DATA_W   = 32,
    parameter int               CFG_W    = 14,
    parameter logic [CFG_W-1:0] CFG_RST  = '0,
    parameter int               MAX_WAIT = 15
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_i2c_regif_if.slave    apb,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    input  logic              TX_EMPTY,
    input  logic              ERROR,
    output logic [CFG_W-1:0]  CONFIG_REG,
    output logic [CFG_W-1:0]  TIMEOUT_REG,
    output logic              IRQ
);
    localparam logic [2:0] A_TX   = 3'd0;
    localparam logic [2:0] A_RX   = 3'd1;
    localparam logic [2:0] A_CFG  = 3'd2;
    localparam logic [2:0] A_TMO  = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4;
    localparam logic [2:0] A_IEN  = 3'd5;
    localparam logic [2:0] A_IPD  = 3'd6;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state;
    logic [7:0]        wcnt;
    logic [2:0]        int_en;
    logic [2:0]        int_pend;
    logic [2:0]        src_q;
    logic [2:0]        src;
    logic [2:0]        pend_set;
    logic [2:0]        pend_clr;
    logic [2:0]        sel;
    logic              access;
    logic              addr_ok;
    logic              bad;
    logic              tx_acc;
    logic              rx_acc;
    logic              reg_acc;
    logic              tmo;
    logic              wr_done;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_addr;

    // Gating with PRESETn drops an in-flight transfer the moment reset asserts.
    assign access      = PRESETn & apb.PSELx & apb.PENABLE;
    assign sel         = apb.PADDR[4:2];
    assign addr_ok     = (apb.PADDR >> 5) == '0;
    assign unused_addr = ^apb.PADDR[1:0];

    always_comb begin
        bad = 1'b0;
        if (!addr_ok) begin
            bad = 1'b1;
        end else begin
            case (sel)
                A_TX:                       bad = !apb.PWRITE;
                A_RX, A_STAT:               bad = apb.PWRITE;
                A_CFG, A_TMO, A_IEN, A_IPD: bad = 1'b0;
                default:                    bad = 1'b1;
            endcase
        end
    end

    assign tx_acc  = access & !bad & (sel == A_TX);
    assign rx_acc  = access & !bad & (sel == A_RX);
    assign reg_acc = access & !bad & !tx_acc & !rx_acc;
    assign tmo     = (tx_acc | rx_acc) & (wcnt == 8'(MAX_WAIT));

    assign TX_DATA     = apb.PWDATA;
    assign TX_VALID    = tx_acc & !tmo;
    assign RX_READY    = rx_acc & !tmo;
    assign apb.PREADY  = access & (bad | reg_acc | tmo |
                                   (TX_VALID & TX_READY) | (RX_READY & RX_VALID));
    assign apb.PSLVERR = access & (bad | tmo);
    assign wr_done     = reg_acc & apb.PWRITE;

    always_comb begin
        rd_mux = '0;
        if (access && !apb.PWRITE && !bad && !tmo) begin
            case (sel)
                A_RX:    rd_mux = RX_DATA;
                A_CFG:   rd_mux = DATA_W'(CONFIG_REG);
                A_TMO:   rd_mux = DATA_W'(TIMEOUT_REG);
                A_STAT:  rd_mux[2:0] = {ERROR, RX_VALID, TX_READY};
                A_IEN:   rd_mux[2:0] = int_en;
                A_IPD:   rd_mux[2:0] = int_pend;
                default: rd_mux = '0;
            endcase
        end
    end
    assign apb.PRDATA = rd_mux;

    assign src      = {ERROR, RX_VALID, TX_EMPTY};
    assign pend_set = src & ~src_q;
    assign pend_clr = (wr_done && sel == A_IPD) ? apb.PWDATA[2:0] : 3'b000;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= S_IDLE;
            wcnt        <= '0;
            int_en      <= '0;
            int_pend    <= '0;
            src_q       <= '0;
            IRQ         <= 1'b0;
            CONFIG_REG  <= CFG_RST;
            TIMEOUT_REG <= CFG_RST;
        end else begin
            src_q    <= src;
            // A new edge wins over a simultaneous write-1-to-clear.
            int_pend <= (int_pend & ~pend_clr) | pend_set;
            IRQ      <= |(int_pend & int_en);

            if (wr_done) begin
                case (sel)
                    A_CFG:   CONFIG_REG  <= apb.PWDATA[CFG_W-1:0];
                    A_TMO:   TIMEOUT_REG <= apb.PWDATA[CFG_W-1:0];
                    A_IEN:   int_en      <= apb.PWDATA[2:0];
                    default: ;
                endcase
            end

            if (!apb.PSELx || apb.PREADY)
                wcnt <= '0;
            else if (tx_acc || rx_acc)
                wcnt <= wcnt + 8'd1;

            case (state)
                S_IDLE: if ((tx_acc || rx_acc) && !apb.PREADY) state <= S_WAIT;
                S_WAIT: if (apb.PREADY || !apb.PSELx)          state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_i2c_regif.sv
// Self-checking bench for apb_i2c_regif: register vector table plus FIFO,
// timeout, interrupt and reset sequences, checked through a scoreboard queue.
module tb_apb_i2c_regif;
    localparam int               ADDR_W   = 8;
    localparam int               DATA_W   = 32;
    localparam int               CFG_W    = 14;
    localparam logic [CFG_W-1:0] CFG_RST  = 14'h0155;
    localparam int               MAX_WAIT = 15;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic [DATA_W-1:0] TX_DATA, RX_DATA;
    logic              TX_VALID, TX_READY, RX_VALID, RX_READY, TX_EMPTY, ERROR, IRQ;
    logic [CFG_W-1:0]  CONFIG_REG, TIMEOUT_REG;

    apb_i2c_regif_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    apb_i2c_regif #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CFG_W(CFG_W),
        .CFG_RST(CFG_RST), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .TX_EMPTY(TX_EMPTY), .ERROR(ERROR),
        .CONFIG_REG(CONFIG_REG), .TIMEOUT_REG(TIMEOUT_REG), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    int          checks = 0;
    int          errors = 0;
    int          push_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] last_push = '0;
    logic        cpl_txv, cpl_rxr;

    always @(posedge PCLK) begin
        if (TX_VALID && TX_READY) begin
            push_cnt++;
            last_push = TX_DATA;
        end
        if (RX_VALID && RX_READY) pop_cnt++;
    end

    typedef struct {
        string       nm;
        bit          chk_rd;
        logic [31:0] rd;
        bit          err;
        int          waits;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          err;
        string       nm;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input bit err, input string nm);
        vec_t v;
        v.wr = wr; v.addr = a; v.wd = wd; v.rd = rd; v.err = err; v.nm = nm;
        vt.push_back(v);
    endtask

    task automatic apb_xfer(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                            input bit chk_rd, input logic [31:0] rd, input bit err,
                            input int waits, input string nm);
        exp_t        e;
        int          w;
        bit          done;
        logic [31:0] got_rd;
        logic        got_err;
        e.nm = nm; e.chk_rd = chk_rd; e.rd = rd; e.err = err; e.waits = waits;
        sb_q.push_back(e);
        @(posedge PCLK); #1;
        bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = a;    bus.PWDATA = wd;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1;
        w = 0; done = 1'b0; got_rd = '0; got_err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge PCLK);
            if (bus.PREADY) begin
                done = 1'b1; got_rd = bus.PRDATA; got_err = bus.PSLVERR;
                cpl_txv = TX_VALID; cpl_rxr = RX_READY;
                break;
            end
            w++;
        end
        @(posedge PCLK); #1;
        bus.PSELx = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        e = sb_q.pop_front();
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s: no PREADY within 40 cycles", e.nm);
        end else begin
            check({e.nm, "_err"}, 32'(got_err), 32'(e.err));
            check({e.nm, "_waits"}, w, e.waits);
            if (e.chk_rd) check({e.nm, "_rdata"}, got_rd, e.rd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] cfg_m, tmo_m;
        int          p0;

        bus.PSELx = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
        TX_READY = 1; RX_VALID = 0; RX_DATA = '0; TX_EMPTY = 0; ERROR = 0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        @(negedge PCLK);
        check("rst_pready", 32'(bus.PREADY), 0);
        check("rst_pslverr", 32'(bus.PSLVERR), 0);
        check("rst_prdata", bus.PRDATA, 0);
        check("rst_irq", 32'(IRQ), 0);
        check("rst_config", 32'(CONFIG_REG), 32'(CFG_RST));
        check("rst_timeout", 32'(TIMEOUT_REG), 32'(CFG_RST));

        add(0, 8'h08, 32'h0,         32'(CFG_RST), 0, "rd_cfg_rst");
        add(0, 8'h0C, 32'h0,         32'(CFG_RST), 0, "rd_tmo_rst");
        add(1, 8'h08, 32'hFFFF_3ABC, 32'h0,        0, "wr_cfg");
        add(0, 8'h08, 32'h0,         32'h3ABC,     0, "rd_cfg");
        add(0, 8'h0C, 32'h0,         32'(CFG_RST), 0, "rd_tmo_unch");
        add(1, 8'h0C, 32'h0000_1234, 32'h0,        0, "wr_tmo");
        add(0, 8'h0C, 32'h0,         32'h1234,     0, "rd_tmo");
        add(0, 8'h10, 32'h0,         32'h1,        0, "rd_status");
        add(1, 8'h10, 32'hFF,        32'h0,        1, "wr_status_ro");
        add(1, 8'h1C, 32'hFF,        32'h0,        1, "wr_unmapped");
        add(0, 8'h1C, 32'h0,         32'h0,        1, "rd_unmapped");
        add(0, 8'h00, 32'h0,         32'h0,        1, "rd_txdata");
        add(1, 8'h04, 32'h1,         32'h0,        1, "wr_rxdata_ro");
        add(1, 8'h14, 32'hFFFF_FFFD, 32'h0,        0, "wr_int_en");
        add(0, 8'h14, 32'h0,         32'h5,        0, "rd_int_en");
        add(1, 8'h28, 32'h0000_0001, 32'h0,        1, "wr_high_addr");
        add(0, 8'h0B, 32'h0,         32'h3ABC,     0, "rd_cfg_low_bits");
        add(0, 8'h18, 32'h0,         32'h0,        0, "rd_pend_zero");

        cfg_m = CFG_RST; tmo_m = CFG_RST;
        foreach (vt[i]) begin
            apb_xfer(vt[i].wr, vt[i].addr, vt[i].wd, !vt[i].wr, vt[i].rd, vt[i].err, 0, vt[i].nm);
            if (vt[i].wr && !vt[i].err && vt[i].addr[7:2] == 6'h02) cfg_m = vt[i].wd[13:0];
            if (vt[i].wr && !vt[i].err && vt[i].addr[7:2] == 6'h03) tmo_m = vt[i].wd[13:0];
            check({vt[i].nm, "_cfgreg"}, 32'(CONFIG_REG), 32'(cfg_m));
            check({vt[i].nm, "_tmoreg"}, 32'(TIMEOUT_REG), 32'(tmo_m));
        end
        check("table_no_push", push_cnt, 0);

        // TX write with three wait states
        TX_READY = 0; p0 = push_cnt;
        fork
            apb_xfer(1, 8'h00, 32'hA5, 0, 0, 0, 3, "tx_wait3");
            begin
                wait (bus.PENABLE === 1'b1);
                repeat (3) @(posedge PCLK);
                #2 TX_READY = 1;
            end
        join
        check("tx_wait3_txv", 32'(cpl_txv), 1);
        check("tx_wait3_pushes", push_cnt - p0, 1);
        check("tx_wait3_data", last_push, 32'hA5);

        TX_READY = 0; p0 = push_cnt;
        apb_xfer(1, 8'h00, 32'h77, 0, 0, 1, MAX_WAIT, "tx_timeout");
        check("tx_timeout_txv", 32'(cpl_txv), 0);
        check("tx_timeout_pushes", push_cnt - p0, 0);
        TX_READY = 1;

        p0 = pop_cnt;
        apb_xfer(0, 8'h04, 32'h0, 0, 0, 1, MAX_WAIT, "rx_timeout");
        check("rx_timeout_rxr", 32'(cpl_rxr), 0);
        check("rx_timeout_pops", pop_cnt - p0, 0);

        RX_VALID = 1; RX_DATA = 32'hDEAD_BEEF; p0 = pop_cnt;
        apb_xfer(0, 8'h04, 32'h0, 1, 32'hDEAD_BEEF, 0, 0, "rx_read");
        check("rx_read_pops", pop_cnt - p0, 1);
        RX_VALID = 0;

        // Interrupts: enable ERROR only, start from a clean pending set
        apb_xfer(1, 8'h14, 32'h4, 0, 0, 0, 0, "int_en_4");
        apb_xfer(1, 8'h18, 32'h7, 0, 0, 0, 0, "clr_all");
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("irq_idle", 32'(IRQ), 0);
        @(posedge PCLK); #1 ERROR = 1;
        @(negedge PCLK);
        @(negedge PCLK);
        check("irq_lag", 32'(IRQ), 0);
        @(negedge PCLK);
        check("irq_set", 32'(IRQ), 1);
        apb_xfer(0, 8'h18, 32'h0, 1, 32'h4, 0, 0, "rd_pend_err");
        apb_xfer(1, 8'h18, 32'h4, 0, 0, 0, 0, "w1c_err");
        @(negedge PCLK);
        check("irq_hold_one", 32'(IRQ), 1);
        @(negedge PCLK);
        check("irq_fall", 32'(IRQ), 0);
        apb_xfer(0, 8'h18, 32'h0, 1, 32'h0, 0, 0, "rd_pend_clr");

        ERROR = 0;
        repeat (2) @(posedge PCLK);
        fork
            apb_xfer(1, 8'h18, 32'h4, 0, 0, 0, 0, "w1c_vs_edge");
            begin
                wait (bus.PENABLE === 1'b1);
                #1 ERROR = 1;
            end
        join
        apb_xfer(0, 8'h18, 32'h0, 1, 32'h4, 0, 0, "rd_pend_setwins");

        TX_EMPTY = 1;
        repeat (2) @(posedge PCLK);
        apb_xfer(0, 8'h18, 32'h0, 1, 32'h5, 0, 0, "rd_pend_txempty");

        // Reset asserted in the middle of a stalled TX write
        TX_READY = 0; p0 = push_cnt;
        @(posedge PCLK); #1;
        bus.PSELx = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 8'h00; bus.PWDATA = 32'h5A;
        @(posedge PCLK); #1 bus.PENABLE = 1;
        @(negedge PCLK);
        @(negedge PCLK);
        check("mid_txv", 32'(TX_VALID), 1);
        #1 PRESETn = 0; TX_EMPTY = 0; ERROR = 0;
        #1;
        check("rst_mid_txv", 32'(TX_VALID), 0);
        check("rst_mid_pready", 32'(bus.PREADY), 0);
        check("rst_mid_irq", 32'(IRQ), 0);
        check("rst_mid_config", 32'(CONFIG_REG), 32'(CFG_RST));
        @(posedge PCLK); #1;
        bus.PSELx = 0; bus.PENABLE = 0; bus.PWRITE = 0;
        TX_READY = 1;
        @(posedge PCLK); #1 PRESETn = 1;
        check("rst_mid_pushes", push_cnt - p0, 0);
        apb_xfer(0, 8'h14, 32'h0, 1, 32'h0, 0, 0, "rd_int_en_after_rst");
        apb_xfer(0, 8'h18, 32'h0, 1, 32'h0, 0, 0, "rd_pend_after_rst");
        p0 = push_cnt;
        apb_xfer(1, 8'h00, 32'h3C, 0, 0, 0, 0, "tx_after_rst");
        check("tx_after_rst_pushes", push_cnt - p0, 1);
        check("tx_after_rst_data", last_push, 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
